// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus of the PS/2 receive FIFO: the scan-code decoder is the master
// (issues rd_en), the receiver FIFO is the slave (presents head byte and status).
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;

  modport master (output rd_en, input rd_data, input empty, input full, input count);
  modport slave  (input rd_en, output rd_data, output empty, output full, output count);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with watchdog and first-word-fall-through byte FIFO.
// Define PS2_RX_ERR_CHECK_EN to validate start/parity/stop bits and raise frame_err.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PS2_CLK,
  input  logic          PS2_DATA,
  ps2_rx_fifo_if.slave  rd,
  output logic          busy,
  output logic          overflow,
  output logic          frame_err,
  output logic          timeout_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [10:0]            r_shift;
  logic [3:0]             r_bitcnt;
  logic [WD_W-1:0]        r_wdog;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_fall;
  logic                   w_bit;
  logic                   w_frame_ok;
  logic                   w_push;
  logic                   w_pop;

  // ---- pin synchronisers and falling-edge detect ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DATA};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_bit  = r_dat_sync[SYNC_STAGES-1];

`ifdef PS2_RX_ERR_CHECK_EN
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{r_shift[10:9], r_shift[0]};
  assign w_frame_ok    = 1'b1;
`endif

  // ---- frame FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- frame FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_fall && (r_bitcnt == 4'd10))        w_state_nxt = S_CHECK;
        else if (!w_fall && (r_wdog == WD_LAST))  w_state_nxt = S_IDLE;
      end
      S_CHECK: w_state_nxt = w_fall ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- frame FSM: outputs ----
  always_comb begin
    busy        = 1'b0;
    timeout_err = 1'b0;
    frame_err   = 1'b0;
    overflow    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_SHIFT: begin
        busy        = 1'b1;
        timeout_err = !w_fall && (r_wdog == WD_LAST);
      end
      S_CHECK: begin
        if (!w_frame_ok)                 frame_err = 1'b1;
        else if (!rd.full || w_pop)      w_push    = 1'b1;
        else                             overflow  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- bit counter and watchdog ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_wdog   <= '0;
    end else begin
      if (w_fall) r_bitcnt <= (r_state == S_SHIFT) ? r_bitcnt + 4'd1 : 4'd1;
      if (w_fall || (r_state != S_SHIFT) || (w_state_nxt != S_SHIFT)) r_wdog <= '0;
      else                                                            r_wdog <= r_wdog + 1'b1;
    end
  end

  // Arrival order is LSB first, so bits shift in from the top.
  always_ff @(posedge clk) begin
    if (w_fall) r_shift <= {w_bit, r_shift[10:1]};
  end

  // ---- FIFO storage and pointers ----
  assign w_pop      = rd.rd_en && !rd.empty;
  assign rd.empty   = (r_count == '0);
  assign rd.full    = (r_count == CNT_MAX);
  assign rd.count   = r_count;
  assign rd.rd_data = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_shift[8:1];
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of frames plus hand-written corner sequences.
module tb_ps2_rx_fifo;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 200;
  localparam int H          = 20;
`ifdef PS2_RX_ERR_CHECK_EN
  localparam int ERRCHK = 1;
`else
  localparam int ERRCHK = 0;
`endif
  localparam int NE = 1 - ERRCHK;

  typedef struct {
    logic [7:0] data;
    logic       bad;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_dat;
  logic busy, overflow, frame_err, timeout_err;

  ps2_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) rd_if ();

  ps2_rx_fifo #(
    .SYNC_STAGES(2), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_dat), .rd(rd_if),
    .busy(busy), .overflow(overflow), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr   = 0;
  int n_ovf    = 0;
  int n_tout   = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1)   n_ferr++;
    if (overflow === 1'b1)    n_ovf++;
    if (timeout_err === 1'b1) n_tout++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad);
    return {1'b1, (~^d) ^ bad, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_dat = f[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad);
    send_bits(mk_frame(d, bad), 0, 10);
    wait_cyc(10);
  endtask

  task automatic pop();
    rd_if.rd_en = 1'b1;
    wait_cyc(1);
    rd_if.rd_en = 1'b0;
  endtask

  vec_t        tbl [6];
  logic [7:0]  q [$];
  int          f0, o0, t0;
  logic [7:0]  b;

  initial begin
    tbl[0] = '{8'hF0, 1'b0, 1,      8'hF0, 0};
    tbl[1] = '{8'h1C, 1'b0, 2,      8'hF0, 0};
    tbl[2] = '{8'h5A, 1'b0, 3,      8'hF0, 0};
    tbl[3] = '{8'h1C, 1'b1, 3 + NE, 8'hF0, ERRCHK};
    tbl[4] = '{8'h00, 1'b0, 4 + NE, 8'hF0, 0};
    tbl[5] = '{8'hFF, 1'b0, 5 + NE, 8'hF0, 0};

    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_if.rd_en = 1'b0;
    wait_cyc(3);
    chk("rst_empty",    rd_if.empty,   1);
    chk("rst_full",     rd_if.full,    0);
    chk("rst_count",    rd_if.count,   0);
    chk("rst_busy",     busy,          0);
    chk("rst_overflow", overflow,      0);
    chk("rst_frame_err", frame_err,    0);
    chk("rst_timeout",  timeout_err,   0);
    chk("rst_rd_data",  rd_if.rd_data, 0);
    rst = 1'b0;
    wait_cyc(2);

    // clean 0x1C frame, busy visible mid-frame
    send_bits(mk_frame(8'h1C, 1'b0), 0, 3);
    chk("busy_mid", busy, 1);
    send_bits(mk_frame(8'h1C, 1'b0), 4, 10);
    wait_cyc(10);
    chk("c1_empty", rd_if.empty, 0);
    chk("c1_data",  rd_if.rd_data, 8'h1C);
    chk("c1_count", rd_if.count, 1);
    chk("c1_busy",  busy, 0);
    pop();
    chk("c1_pop_empty", rd_if.empty, 1);
    chk("c1_pop_count", rd_if.count, 0);

    // table: frames queued without pops, then drained in order
    for (int i = 0; i < 6; i++) begin
      f0 = n_ferr;
      send_byte(tbl[i].data, tbl[i].bad);
      chk($sformatf("tbl%0d_count", i), rd_if.count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_head", i),  rd_if.rd_data, tbl[i].exp_head);
      chk($sformatf("tbl%0d_ferr", i),  n_ferr - f0, tbl[i].exp_ferr);
      if (tbl[i].exp_ferr == 0) q.push_back(tbl[i].data);
    end
    while (q.size() > 0) begin
      chk("drain_count", rd_if.count, q.size());
      chk("drain_data",  rd_if.rd_data, q[0]);
      pop();
      void'(q.pop_front());
    end
    chk("drain_empty", rd_if.empty, 1);

    // stalled frame then a good one
    t0 = n_tout;
    send_bits(mk_frame(8'h5A, 1'b0), 0, 4);
    wait_cyc(TIMEOUT + 10);
    chk("to_pulse", n_tout - t0, 1);
    chk("to_busy",  busy, 0);
    chk("to_empty", rd_if.empty, 1);
    send_byte(8'h5A, 1'b0);
    chk("to_data",   rd_if.rd_data, 8'h5A);
    chk("to_count",  rd_if.count, 1);
    chk("to_single", n_tout - t0, 1);
    pop();

    // FIFO_DEPTH+1 frames without pops
    o0 = n_ovf;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      b = 8'(i * 17 + 3);
      send_byte(b, 1'b0);
      if (i == FIFO_DEPTH - 2) chk("ovf_notfull", rd_if.full, 0);
      if (i == FIFO_DEPTH - 1) begin
        chk("ovf_full",  rd_if.full, 1);
        chk("ovf_none",  n_ovf - o0, 0);
      end
    end
    chk("ovf_pulse", n_ovf - o0, 1);
    chk("ovf_count", rd_if.count, FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'(i * 17 + 3);
      chk("ovf_data", rd_if.rd_data, b);
      pop();
    end
    chk("ovf_empty", rd_if.empty, 1);

    // reset mid-frame with FIFO holding data
    send_byte(8'h1C, 1'b0);
    send_bits(mk_frame(8'hF0, 1'b0), 0, 5);
    f0 = n_ferr; o0 = n_ovf; t0 = n_tout;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    chk("rs_empty", rd_if.empty, 1);
    chk("rs_busy",  busy, 0);
    chk("rs_errs",  (n_ferr - f0) + (n_ovf - o0) + (n_tout - t0), 0);
    wait_cyc(2);
    send_byte(8'hF0, 1'b0);
    chk("rs_data",  rd_if.rd_data, 8'hF0);
    chk("rs_count", rd_if.count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver that succeeds the fixed 11-bit shift capture. It runs entirely in the system `clk` domain and oversamples and synchronises `PS2_CLK`/`PS2_DATA`. It frames start/data/parity/stop, recovers from stalled frames with a timeout, and queues received scan-code bytes in a first-word-fall-through FIFO. It sits between the keyboard pins and the calculator's scan-code decoder, which pops bytes at its own pace.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `PS2_CLK` and `PS2_DATA`; minimum 2.
- `FIFO_DEPTH`, default 8: byte entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, default 5000: `clk` cycles with no falling edge before a partial frame is aborted (100 us at 50 MHz).
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `PS2_CLK` input 1: raw PS/2 clock pin, asynchronous.
- `PS2_DATA` input 1: raw PS/2 data pin, asynchronous.
- `rd_en` input 1: pops the head entry when `empty`=0; ignored when `empty`=1.
- `rd_data` output 8: head byte, valid whenever `empty`=0.
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `count` output $clog2(FIFO_DEPTH)+1: occupancy.
- `busy` output 1: a frame is in progress (state SHIFT).
- `overflow` output 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- `frame_err` output 1: one-cycle pulse on a bad start, parity or stop bit.
- `timeout_err` output 1: one-cycle pulse when a partial frame is aborted.

## Operation
- Synchronisers: the sync chains reset to 1. A falling edge means sync'd clock previous=1 and current=0. The data bit is sampled from sync'd `PS2_DATA` in that same cycle.
- Frame layout, in arrival order: bit0 start=0, bits1-8 data LSB first, bit9 odd parity (data+parity have an odd number of ones), bit10 stop=1.
- FSM states are IDLE, SHIFT and CHECK.
- IDLE: on a falling edge, shift the bit in, set bit counter=1 and go to SHIFT.
- SHIFT: each falling edge shifts the bit in and increments the counter. When the counter reaches 11, go to CHECK.
- SHIFT timeout: a watchdog counter clears on every falling edge. If it reaches `TIMEOUT_CYCLES` in SHIFT, pulse `timeout_err`, clear the counter and go to IDLE.
- CHECK, one cycle: validate the frame, write to the FIFO if it passes, then go to IDLE. A falling edge arriving during CHECK is treated as the start of the next frame.
- FIFO: circular buffer with wrapping read and write pointers.
- Push when the frame is good and either `full`=0, or `full`=1 with an accepted `rd_en` in the same cycle. Otherwise pulse `overflow` and discard the byte.
- Pop and push in the same cycle leave `count` unchanged.
- `rd_data` shows the head entry combinationally from the memory and the read pointer. Its value when `empty`=1 is don't-care, but it must not be X after reset.
- Reset mid-frame discards the partial frame and the FIFO contents. No error pulse is raised.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `busy`=0, `overflow`=0, `frame_err`=0, `timeout_err`=0, `rd_data`=0. FSM=IDLE, pointers=0, sync chains=1.
- Pin-to-edge latency: a pin transition becomes a detected edge `SYNC_STAGES`+1 cycles later.
- Frame latency: the 11th falling-edge detect is cycle N and CHECK is cycle N+1. `empty` falls and `count` increments at N+2; `frame_err` and `overflow` pulse at N+1.
- Pop: `rd_en` accepted at cycle M gives new `rd_data`/`count` at M+1.
- `busy` is 1 from the cycle after the first falling edge through the last SHIFT cycle.

## Configuration
- `PS2_RX_ERR_CHECK_EN` defined: in CHECK, a frame with start≠0, stop≠1 or wrong parity pulses `frame_err` and is not written.
- `PS2_RX_ERR_CHECK_EN` undefined: bits 0, 9 and 10 are ignored, every complete frame is pushed, and `frame_err` is tied 0.
- Timeout and overflow behave the same in both builds.

## Test plan
- Clean frame for 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 sent at 12 kHz -> `empty` falls, `rd_data`=0x1C, `count`=1. After one `rd_en`, `empty`=1.
- Sequence 0xF0 (parity 1), 0x1C, 0x5A (parity 1) with no pops -> reads return 0xF0, 0x1C, 0x5A in order; `count` steps 3,2,1,0.
- 0x1C frame with parity bit flipped to 1 -> `frame_err` pulses once and FIFO stays empty (with the macro). Without the macro, 0x1C is pushed and `frame_err` stays 0.
- 5 bits sent then `PS2_CLK` held high for `TIMEOUT_CYCLES`+10 cycles, then a full 0x5A frame -> one `timeout_err` pulse, then `rd_data`=0x5A.
- `FIFO_DEPTH`+1 frames sent with no pops -> `full`=1 after the 8th, one `overflow` pulse on the 9th, and the first 8 bytes are intact.
- `rst` asserted after 6 bits, then released and a 0xF0 frame sent -> `empty`=1 with no error pulses during reset, then `rd_data`=0xF0.
